updown_counter: RTL and testbench
=================================

Name: updown_counter

Overview:
- Synchronous up/down binary counter with a bit-inverted mirror output.
- Used as a general-purpose event/position counter.
- Also used as a formal-property target: the count steps by exactly one per qualified cycle, and the mirror output is always the bitwise complement of the count.
- Single clock domain; asynchronous active-low reset.

Parameters:
- WIDTH, 4, counter width in bits (min 2).
- RST_VAL, 0, count value loaded on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset: 0 = in reset; 1 = run.
- up  input  1  increment request.
- down  input  1  decrement request.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- cnt  output  WIDTH  current count (registered).
- inverted_cnt  output  WIDTH  bitwise complement of cnt.
- at_max  output  1  high when cnt == all ones.
- at_min  output  1  high when cnt == 0.
- wrapped  output  1  one-cycle pulse on the cycle after a wrap or saturation hit.

Behaviour:
- Reset:
  - reset=0 forces cnt=RST_VAL immediately, independent of clk.
  - Also forces wrapped=0, inverted_cnt=~RST_VAL, at_min=(RST_VAL==0), at_max=(RST_VAL==all ones).
  - Reset deassertion is taken on the next rising clk edge. The first count update occurs on the first rising edge with reset=1.
- Priority per rising edge (reset=1): load > (up XOR down) > hold.
  - load=1: cnt <= load_val; wrapped <= 0; up/down ignored.
  - up=1, down=0: cnt <= cnt + 1 (mod 2^WIDTH).
  - down=1, up=0: cnt <= cnt - 1 (mod 2^WIDTH).
  - up=down=1, or both 0: cnt holds; wrapped <= 0.
- Latency: one clock from request to updated cnt. A constant up level advances cnt by N after N edges, e.g. up for 2 cycles gives cnt(t) = cnt(t-2) + 2.
- Wrap-around (default build):
  - Up at all ones gives 0; down at 0 gives all ones.
  - wrapped <= 1 on that edge only; otherwise wrapped <= 0.
- inverted_cnt = ~cnt at all times, combinational from the cnt register. No extra latency; identical in reset.
- at_max and at_min are combinational decodes of cnt.
- All outputs are free of X after reset.
- No internal state beyond the cnt and wrapped registers.

Optional Feature:
- Macro: UPDOWN_COUNTER_SATURATE_EN.
- Defined:
  - Counter saturates: up at all ones holds all ones; down at 0 holds 0.
  - wrapped pulses for one cycle on each such blocked request. It is renamed in intent to "saturation hit", with the same port.
  - Load and reset behaviour unchanged.
- Undefined: modular wrap-around as described in Behaviour.

Test Plan:
- Reset: hold reset=0 mid-count at cnt=7 → cnt=0, inverted_cnt=4'hF, at_min=1 without waiting for clk. Release reset → cnt stays 0 until the first up edge.
- Increment: up=1 for 3 edges from 0 → cnt=1,2,3 on successive edges; inverted_cnt=E,D,C. Check cnt == $past(cnt)+1 every cycle.
- Wrap up/down: load 4'hF, then up=1 for 1 edge → cnt=0, wrapped=1 for one cycle. Then down=1 for 1 edge → cnt=F, wrapped=1. With UPDOWN_COUNTER_SATURATE_EN: cnt stays F, then 0 at the respective limits, with wrapped pulsing.
- Simultaneous: up=down=1 at cnt=5 for 4 edges → cnt stays 5, wrapped=0. Then load=1, load_val=9, up=1 on the same edge → cnt=9 (load wins).
- Two-cycle property: random up/down/hold sequence of 1000 cycles with sporadic async resets. Every cycle: inverted_cnt == ~cnt. Up held 2 cycles gives cnt == $past(cnt,2)+2 mod 16. at_max/at_min match decodes.

Source files
------------

// File: rtl/updown_counter_if.sv
// Bus interface for updown_counter: count requests in, count/status out.
// The counter drives its outputs through the slave modport.
interface updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             up;
    logic             down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] inverted_cnt;
    logic             at_max;
    logic             at_min;
    logic             wrapped;

    modport master (
        output up,
        output down,
        output load,
        output load_val,
        input  cnt,
        input  inverted_cnt,
        input  at_max,
        input  at_min,
        input  wrapped
    );

    modport slave (
        input  up,
        input  down,
        input  load,
        input  load_val,
        output cnt,
        output inverted_cnt,
        output at_max,
        output at_min,
        output wrapped
    );
endinterface

// File: rtl/updown_counter.sv
// Up/down binary counter with bitwise-inverted mirror and limit decodes.
// Define UPDOWN_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module updown_counter #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    updown_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrapped;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_wrapped_nxt;

    // Next-state selection: load beats a single-direction request, anything else holds.
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_wrapped_nxt = 1'b0;
        if (bus.load) begin
            w_cnt_nxt     = bus.load_val;
            w_wrapped_nxt = 1'b0;
        end else begin
            case ({bus.up, bus.down})
                2'b10: begin
                    if (r_cnt == CNT_MAX) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                        w_cnt_nxt = CNT_MAX;
`else
                        w_cnt_nxt = CNT_MIN;
`endif
                        w_wrapped_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt     = r_cnt + CNT_ONE;
                        w_wrapped_nxt = 1'b0;
                    end
                end
                2'b01: begin
                    if (r_cnt == CNT_MIN) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                        w_cnt_nxt = CNT_MIN;
`else
                        w_cnt_nxt = CNT_MAX;
`endif
                        w_wrapped_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt     = r_cnt - CNT_ONE;
                        w_wrapped_nxt = 1'b0;
                    end
                end
                default: begin
                    w_cnt_nxt     = r_cnt;
                    w_wrapped_nxt = 1'b0;
                end
            endcase
        end
    end

    // Count and wrap-pulse registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= RST_VAL;
            r_wrapped <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_wrapped <= w_wrapped_nxt;
        end
    end

    assign bus.cnt          = r_cnt;
    assign bus.inverted_cnt = ~r_cnt;
    assign bus.at_max       = (r_cnt == CNT_MAX);
    assign bus.at_min       = (r_cnt == CNT_MIN);
    assign bus.wrapped      = r_wrapped;

endmodule

// File: tb/tb_updown_counter.sv
// Directed and model-checked random bench for updown_counter (WIDTH=4, RST_VAL=0).
module tb_updown_counter;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    updown_counter_if #(.WIDTH(4)) bus ();

    updown_counter #(.WIDTH(4), .RST_VAL(4'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_cnt, input logic e_wrap);
        check_val({tag, ".cnt"}, {28'h0, bus.cnt}, {28'h0, e_cnt});
        check_val({tag, ".inv"}, {28'h0, bus.inverted_cnt}, {28'h0, ~e_cnt});
        check_val({tag, ".max"}, {31'h0, bus.at_max}, {31'h0, (e_cnt == 4'hF)});
        check_val({tag, ".min"}, {31'h0, bus.at_min}, {31'h0, (e_cnt == 4'h0)});
        check_val({tag, ".wrap"}, {31'h0, bus.wrapped}, {31'h0, e_wrap});
    endtask

    logic [3:0] m_cnt;
    logic       m_wrap;
    logic [3:0] h1;
    logic [3:0] h2;
    int         up_run;
    logic [3:0] exp2;

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        reset        = 1'b0;
        bus.up       = 1'b0;
        bus.down     = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 4'h0;

        // Reset state
        step();
        step();
        check_all("rst", 4'h0, 1'b0);
        reset = 1'b1;
        step();
        check_all("rel_hold", 4'h0, 1'b0);

        // Increment from 0
        bus.up = 1'b1;
        step(); check_all("inc1", 4'h1, 1'b0);
        step(); check_all("inc2", 4'h2, 1'b0);
        step(); check_all("inc3", 4'h3, 1'b0);
        step(); step(); step(); step();
        check_all("inc7", 4'h7, 1'b0);
        bus.up = 1'b0;

        // Asynchronous reset mid-cycle at cnt=7
        #2 reset = 1'b0;
        #1 check_all("async_rst", 4'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(); check_all("post_rst", 4'h0, 1'b0);
        bus.up = 1'b1;
        step(); check_all("first_up", 4'h1, 1'b0);
        bus.up = 1'b0;

        // Upper limit
        bus.load = 1'b1; bus.load_val = 4'hF;
        step(); check_all("load_f", 4'hF, 1'b0);
        bus.load = 1'b0; bus.up = 1'b1;
        step();
`ifdef UPDOWN_COUNTER_SATURATE_EN
        check_all("up_limit", 4'hF, 1'b1);
`else
        check_all("up_limit", 4'h0, 1'b1);
`endif
        bus.up = 1'b0;
        step();
`ifdef UPDOWN_COUNTER_SATURATE_EN
        check_all("up_pulse_end", 4'hF, 1'b0);
`else
        check_all("up_pulse_end", 4'h0, 1'b0);
`endif

        // Lower limit
        bus.load = 1'b1; bus.load_val = 4'h0;
        step(); check_all("load_0", 4'h0, 1'b0);
        bus.load = 1'b0; bus.down = 1'b1;
        step();
`ifdef UPDOWN_COUNTER_SATURATE_EN
        check_all("dn_limit", 4'h0, 1'b1);
`else
        check_all("dn_limit", 4'hF, 1'b1);
`endif
        bus.down = 1'b0;
        step();
`ifdef UPDOWN_COUNTER_SATURATE_EN
        check_all("dn_pulse_end", 4'h0, 1'b0);
`else
        check_all("dn_pulse_end", 4'hF, 1'b0);
`endif

        // Plain decrement
        bus.load = 1'b1; bus.load_val = 4'hA;
        step();
        bus.load = 1'b0; bus.down = 1'b1;
        step(); check_all("dec", 4'h9, 1'b0);
        bus.down = 1'b0;

        // Simultaneous up and down hold; load wins over up
        bus.load = 1'b1; bus.load_val = 4'h5;
        step();
        bus.load = 1'b0; bus.up = 1'b1; bus.down = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_all("both", 4'h5, 1'b0);
        end
        bus.down = 1'b0; bus.load = 1'b1; bus.load_val = 4'h9;
        step(); check_all("load_win", 4'h9, 1'b0);
        bus.load = 1'b0; bus.up = 1'b0;

        // Random sequence against a reference model
        m_cnt  = 4'h9;
        m_wrap = 1'b0;
        h1     = m_cnt;
        h2     = m_cnt;
        up_run = 0;
        for (int c = 0; c < 1000; c++) begin
            int r;
            r = $urandom_range(0, 9);
            bus.up = 1'b0; bus.down = 1'b0; bus.load = 1'b0;
            bus.load_val = 4'($urandom_range(0, 15));
            if (r <= 3 || r == 9) bus.up = 1'b1;
            else if (r <= 5) bus.down = 1'b1;
            else if (r == 6) begin bus.up = 1'b1; bus.down = 1'b1; end
            else if (r == 8 && ($urandom_range(0, 2) == 0)) bus.load = 1'b1;

            h2 = h1;
            h1 = m_cnt;
            if (bus.load) begin
                m_cnt = bus.load_val; m_wrap = 1'b0; up_run = 0;
            end else if (bus.up && !bus.down) begin
                up_run++;
                m_wrap = (m_cnt == 4'hF);
`ifdef UPDOWN_COUNTER_SATURATE_EN
                if (m_cnt != 4'hF) m_cnt = m_cnt + 4'h1;
`else
                m_cnt = m_cnt + 4'h1;
`endif
            end else if (bus.down && !bus.up) begin
                up_run = 0;
                m_wrap = (m_cnt == 4'h0);
`ifdef UPDOWN_COUNTER_SATURATE_EN
                if (m_cnt != 4'h0) m_cnt = m_cnt - 4'h1;
`else
                m_cnt = m_cnt - 4'h1;
`endif
            end else begin
                m_wrap = 1'b0; up_run = 0;
            end
            step();
            check_all("rnd", m_cnt, m_wrap);
            if (up_run >= 2) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                exp2 = (h2 >= 4'hD) ? 4'hF : h2 + 4'h2;
`else
                exp2 = h2 + 4'h2;
`endif
                check_val("two_cycle", {28'h0, bus.cnt}, {28'h0, exp2});
            end

            if ($urandom_range(0, 49) == 0) begin
                #2 reset = 1'b0;
                #1;
                m_cnt = 4'h0; m_wrap = 1'b0; up_run = 0;
                h1 = m_cnt;
                check_all("rnd_rst", m_cnt, m_wrap);
                @(negedge clk);
                reset = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
